// File: rtl/rotator_pkg.sv
// rotator_pkg: shared beat type, widths and byte/bit rotate helpers for the AXIS byte rotator
package rotator_pkg;
    localparam int WIDTH        = 512;
    localparam int BYTES        = WIDTH / 8;
    localparam int OFFSET_WIDTH = $clog2(BYTES) + 1;
    localparam int NUM_STAGES   = $clog2(BYTES);

    typedef struct packed {
        logic [WIDTH-1:0]        data;
        logic [BYTES-1:0]        keep;
        logic                    last;
        logic [OFFSET_WIDTH-1:0] offset;
        logic                    dir;
    } rot_beat_t;

    // dir=0 moves byte k to k+n, dir=1 moves byte k to k-n (mod BYTES)
    function automatic logic [WIDTH-1:0] rot_bytes(input logic [WIDTH-1:0] data, input int unsigned n, input logic dir);
        logic [WIDTH-1:0] r;
        int unsigned src;
        r = '0;
        for (int j = 0; j < BYTES; j++) begin
            src = dir ? (j + n) % BYTES : (j + BYTES - n % BYTES) % BYTES;
            r[8*j +: 8] = data[8*src +: 8];
        end
        return r;
    endfunction

    function automatic logic [BYTES-1:0] rot_keep(input logic [BYTES-1:0] keep, input int unsigned n, input logic dir);
        logic [BYTES-1:0] r;
        int unsigned src;
        r = '0;
        for (int j = 0; j < BYTES; j++) begin
            src = dir ? (j + n) % BYTES : (j + BYTES - n % BYTES) % BYTES;
            r[j] = keep[src];
        end
        return r;
    endfunction
endpackage

// File: rtl/axis_rotate_stage.sv
// axis_rotate_stage: one binary rotate stage (2^STAGE_IDX bytes) with optional handshaked pipeline register
module axis_rotate_stage
    import rotator_pkg::*;
#(
    parameter int STAGE_IDX = 0,
    parameter bit REGISTER  = 1'b1
) (
    input  logic      aclk,
    input  logic      aresetn,
    input  rot_beat_t up_beat,
    input  logic      up_valid,
    output logic      up_ready,
    output rot_beat_t down_beat,
    output logic      down_valid,
    input  logic      down_ready
);
    rot_beat_t rot;

    always_comb begin
        rot      = up_beat;
        rot.data = up_beat.offset[STAGE_IDX] ? rot_bytes(up_beat.data, 2 ** STAGE_IDX, up_beat.dir) : up_beat.data;
        rot.keep = up_beat.offset[STAGE_IDX] ? rot_keep(up_beat.keep, 2 ** STAGE_IDX, up_beat.dir) : up_beat.keep;
    end

    generate
        if (REGISTER) begin : g_reg
            logic      valid_q;
            rot_beat_t beat_q;
            // an empty slot always accepts, so bubbles never hold back upstream
            assign up_ready   = !valid_q || down_ready;
            assign down_valid = valid_q;
            assign down_beat  = beat_q;
            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    valid_q <= 1'b0;
                    beat_q  <= '0;
                end else if (up_ready) begin
                    valid_q <= up_valid;
                    beat_q  <= rot;
                end
            end
        end else begin : g_comb
            assign up_ready   = down_ready;
            assign down_valid = up_valid;
            assign down_beat  = rot;
        end
    endgenerate
endmodule

// File: rtl/axis_byte_rotator.sv
// axis_byte_rotator: pipelined AXIS byte rotator; define AXIS_BYTE_ROTATOR_STATS_EN for beat/packet counters
module axis_byte_rotator #(
    parameter int WIDTH        = rotator_pkg::WIDTH,
    parameter int BYTES        = WIDTH / 8,
    parameter int OFFSET_WIDTH = $clog2(BYTES) + 1,
    parameter int NUM_STAGES   = $clog2(BYTES),
    parameter logic [NUM_STAGES-1:0] REG_MASK = '1
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [WIDTH-1:0]        s_tdata,
    input  logic [BYTES-1:0]        s_tkeep,
    input  logic                    s_tlast,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic [OFFSET_WIDTH-1:0] s_offset,
    input  logic                    s_dir,
    output logic [WIDTH-1:0]        m_tdata,
    output logic [BYTES-1:0]        m_tkeep,
    output logic                    m_tlast,
    output logic                    m_tvalid,
    input  logic                    m_tready,
`ifdef AXIS_BYTE_ROTATOR_STATS_EN
    output logic [OFFSET_WIDTH-1:0] m_offset,
    output logic [31:0]             o_beat_cnt,
    output logic [31:0]             o_pkt_cnt
`else
    output logic [OFFSET_WIDTH-1:0] m_offset
`endif
);
    import rotator_pkg::*;

    rot_beat_t [NUM_STAGES:0] beat;
    logic [NUM_STAGES:0]      valid;
    logic [NUM_STAGES:0]      ready;
    logic                     unused_dir;

    assign beat[0]           = '{data: s_tdata, keep: s_tkeep, last: s_tlast, offset: s_offset, dir: s_dir};
    assign valid[0]          = s_tvalid;
    assign s_tready          = ready[0];
    assign ready[NUM_STAGES] = m_tready;

    genvar s;
    generate
        for (s = 0; s < NUM_STAGES; s++) begin : g_stage
            axis_rotate_stage #(
                .STAGE_IDX(s),
                .REGISTER (REG_MASK[s])
            ) u_stage (
                .aclk      (aclk),
                .aresetn   (aresetn),
                .up_beat   (beat[s]),
                .up_valid  (valid[s]),
                .up_ready  (ready[s]),
                .down_beat (beat[s+1]),
                .down_valid(valid[s+1]),
                .down_ready(ready[s+1])
            );
        end
    endgenerate

    assign m_tdata    = beat[NUM_STAGES].data;
    assign m_tkeep    = beat[NUM_STAGES].keep;
    assign m_tlast    = beat[NUM_STAGES].last;
    assign m_offset   = beat[NUM_STAGES].offset;
    assign m_tvalid   = valid[NUM_STAGES];
    assign unused_dir = beat[NUM_STAGES].dir;

`ifdef AXIS_BYTE_ROTATOR_STATS_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            o_beat_cnt <= '0;
            o_pkt_cnt  <= '0;
        end else if (m_tvalid && m_tready) begin
            o_beat_cnt <= o_beat_cnt + 32'd1;
            if (m_tlast) o_pkt_cnt <= o_pkt_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_axis_byte_rotator.sv
// tb_axis_byte_rotator: directed and random checks of the AXIS byte rotator
module tb_axis_byte_rotator;
    import rotator_pkg::*;
    localparam int W = 512;
    localparam int B = 64;
    localparam int OW = 7;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic [W-1:0] s_tdata, m_tdata, x_tdata, c_tdata, r_tdata;
    logic [B-1:0] s_tkeep, m_tkeep, x_tkeep, c_tkeep, r_tkeep;
    logic [OW-1:0] s_offset, m_offset, x_offset, c_offset, r_offset;
    logic s_tlast, s_tvalid, s_tready, s_dir, m_tlast, m_tvalid, m_tready;
    logic x_tlast, x_tvalid, x_dir, x_tready, c_s_tready, r_s_tready;
    logic c_tlast, c_tvalid, r_tlast, r_tvalid;
`ifdef AXIS_BYTE_ROTATOR_STATS_EN
    logic [31:0] beat_cnt, pkt_cnt, c_beat_cnt, c_pkt_cnt, r_beat_cnt, r_pkt_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [W-1:0] ramp;

    axis_byte_rotator u_dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_offset(s_offset), .s_dir(s_dir),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
`ifdef AXIS_BYTE_ROTATOR_STATS_EN
        .o_beat_cnt(beat_cnt), .o_pkt_cnt(pkt_cnt),
`endif
        .m_offset(m_offset)
    );

    axis_byte_rotator #(.REG_MASK(6'b000000)) u_comb (
        .aclk(aclk), .aresetn(aresetn),
        .s_tdata(x_tdata), .s_tkeep(x_tkeep), .s_tlast(x_tlast), .s_tvalid(x_tvalid), .s_tready(c_s_tready),
        .s_offset(x_offset), .s_dir(x_dir),
        .m_tdata(c_tdata), .m_tkeep(c_tkeep), .m_tlast(c_tlast), .m_tvalid(c_tvalid), .m_tready(x_tready),
`ifdef AXIS_BYTE_ROTATOR_STATS_EN
        .o_beat_cnt(c_beat_cnt), .o_pkt_cnt(c_pkt_cnt),
`endif
        .m_offset(c_offset)
    );

    axis_byte_rotator #(.REG_MASK(6'b000100)) u_mid (
        .aclk(aclk), .aresetn(aresetn),
        .s_tdata(x_tdata), .s_tkeep(x_tkeep), .s_tlast(x_tlast), .s_tvalid(x_tvalid), .s_tready(r_s_tready),
        .s_offset(x_offset), .s_dir(x_dir),
        .m_tdata(r_tdata), .m_tkeep(r_tkeep), .m_tlast(r_tlast), .m_tvalid(r_tvalid), .m_tready(x_tready),
`ifdef AXIS_BYTE_ROTATOR_STATS_EN
        .o_beat_cnt(r_beat_cnt), .o_pkt_cnt(r_pkt_cnt),
`endif
        .m_offset(r_offset)
    );

    task automatic test_reset();
        aresetn = 1'b0;
        s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_offset = '0; s_dir = 1'b0; m_tready = 1'b1;
        x_tvalid = 1'b0; x_tdata = '0; x_tkeep = '0; x_tlast = 1'b0; x_offset = '0; x_dir = 1'b0; x_tready = 1'b1;
        #12;
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b want 0", m_tvalid); end
        checks++; if (m_tdata !== '0) begin errors++; $display("FAIL rst_tdata got %h want 0", m_tdata); end
        checks++; if (m_tkeep !== '0) begin errors++; $display("FAIL rst_tkeep got %h want 0", m_tkeep); end
        checks++; if (m_offset !== '0) begin errors++; $display("FAIL rst_offset got %h want 0", m_offset); end
        checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast got %b want 0", m_tlast); end
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL rst_s_tready got %b want 1", s_tready); end
        x_tready = 1'b0; #1;
        checks++; if (c_s_tready !== 1'b0) begin errors++; $display("FAIL comb_ready_lo got %b want 0", c_s_tready); end
        x_tready = 1'b1; #1;
        checks++; if (c_s_tready !== 1'b1) begin errors++; $display("FAIL comb_ready_hi got %b want 1", c_s_tready); end
    endtask

    task automatic test_rotate(input logic [OW-1:0] off, input logic dir, input logic [B-1:0] keep,
                               input logic [B-1:0] exp_keep, input int b0, input int b63, input string name);
        logic [W-1:0] exp;
        int n, lat;
        n = int'(off) % B;
        for (int j = 0; j < B; j++) exp[8*j +: 8] = 8'(dir ? (j + n) % B : (j + B - n) % B);
        @(posedge aclk); #1;
        s_tdata = ramp; s_tkeep = keep; s_tlast = 1'b1; s_offset = off; s_dir = dir; s_tvalid = 1'b1; m_tready = 1'b1;
        @(posedge aclk); #1;
        s_tvalid = 1'b0;
        lat = 1;
        while (!m_tvalid && lat < 20) begin @(posedge aclk); #1; lat++; end
        checks++; if (lat != 6) begin errors++; $display("FAIL %s latency got %0d want 6", name, lat); end
        checks++; if (m_tdata !== exp) begin errors++; $display("FAIL %s tdata got %h want %h", name, m_tdata, exp); end
        checks++; if (m_tdata[7:0] !== 8'(b0)) begin errors++; $display("FAIL %s byte0 got %0d want %0d", name, m_tdata[7:0], b0); end
        checks++; if (m_tdata[511:504] !== 8'(b63)) begin errors++; $display("FAIL %s byte63 got %0d want %0d", name, m_tdata[511:504], b63); end
        checks++; if (m_tkeep !== exp_keep) begin errors++; $display("FAIL %s tkeep got %h want %h", name, m_tkeep, exp_keep); end
        checks++; if (m_offset !== off) begin errors++; $display("FAIL %s offset got %0d want %0d", name, m_offset, off); end
        checks++; if (m_tlast !== 1'b1) begin errors++; $display("FAIL %s tlast got %b want 1", name, m_tlast); end
    endtask

    task automatic test_comb();
        @(posedge aclk); #1;
        x_tdata = ramp; x_offset = 7'd2; x_dir = 1'b0; x_tkeep = 64'h3; x_tlast = 1'b1; x_tvalid = 1'b1; x_tready = 1'b0;
        #1;
        checks++; if (c_tvalid !== 1'b1) begin errors++; $display("FAIL comb_valid got %b want 1", c_tvalid); end
        checks++; if (c_s_tready !== 1'b0) begin errors++; $display("FAIL comb_stall_ready got %b want 0", c_s_tready); end
        checks++; if (c_tdata[7:0] !== 8'd62) begin errors++; $display("FAIL comb_byte0 got %0d want 62", c_tdata[7:0]); end
        checks++; if (c_tdata[47:40] !== 8'd3) begin errors++; $display("FAIL comb_byte5 got %0d want 3", c_tdata[47:40]); end
        checks++; if (c_tkeep !== 64'hC) begin errors++; $display("FAIL comb_tkeep got %h want c", c_tkeep); end
        x_tready = 1'b1; #1;
        checks++; if (c_s_tready !== 1'b1) begin errors++; $display("FAIL comb_go_ready got %b want 1", c_s_tready); end
        x_tvalid = 1'b0; #1;
        checks++; if (c_tvalid !== 1'b0) begin errors++; $display("FAIL comb_invalid got %b want 0", c_tvalid); end
    endtask

    task automatic test_mask_one();
        @(posedge aclk); #1;
        x_tdata = ramp; x_offset = 7'd5; x_dir = 1'b1; x_tkeep = 64'h20; x_tlast = 1'b0; x_tvalid = 1'b1; x_tready = 1'b1;
        #1;
        checks++; if (r_tvalid !== 1'b0) begin errors++; $display("FAIL mid_early got %b want 0", r_tvalid); end
        @(posedge aclk); #1;
        x_tvalid = 1'b0;
        checks++; if (r_tvalid !== 1'b1) begin errors++; $display("FAIL mid_latency got %b want 1", r_tvalid); end
        checks++; if (r_tdata[7:0] !== 8'd5) begin errors++; $display("FAIL mid_byte0 got %0d want 5", r_tdata[7:0]); end
        checks++; if (r_tkeep !== 64'h1) begin errors++; $display("FAIL mid_tkeep got %h want 1", r_tkeep); end
        @(posedge aclk); #1;
    endtask

    task automatic rand_beat();
        for (int i = 0; i < 16; i++) s_tdata[32*i +: 32] = $urandom;
        s_tkeep = {$urandom, $urandom};
        s_offset = 7'($urandom);
        s_dir = 1'($urandom);
        s_tlast = 1'($urandom);
    endtask

    task automatic test_random();
        rot_beat_t q[$];
        rot_beat_t exp, held;
        int sent, got, cyc;
        logic in_acc, out_acc, stall;
        sent = 0; got = 0; cyc = 0; stall = 1'b0; held = '0;
        @(posedge aclk); #1;
        rand_beat();
        s_tvalid = 1'($urandom); m_tready = 1'($urandom);
        while (got < 1000 && cyc < 20000) begin
            @(negedge aclk);
            in_acc = s_tvalid && s_tready;
            out_acc = m_tvalid && m_tready;
            if (stall) begin
                checks++;
                if (m_tvalid !== 1'b1 || m_tdata !== held.data || m_tkeep !== held.keep || m_tlast !== held.last || m_offset !== held.offset) begin
                    errors++; $display("FAIL stall_stable beat %0d got v=%b off=%0d want off=%0d", got, m_tvalid, m_offset, held.offset);
                end
            end
            if (out_acc) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_extra beat got off=%0d want none", m_offset);
                end else begin
                    exp = q.pop_front();
                    if (m_tdata !== exp.data || m_tkeep !== exp.keep || m_tlast !== exp.last || m_offset !== exp.offset) begin
                        errors++; $display("FAIL rand_beat %0d got keep=%h off=%0d want keep=%h off=%0d", got, m_tkeep, m_offset, exp.keep, exp.offset);
                    end
                end
                got++;
            end
            stall = m_tvalid && !m_tready;
            held = '{data: m_tdata, keep: m_tkeep, last: m_tlast, offset: m_offset, dir: 1'b0};
            if (in_acc) begin
                q.push_back('{data: rot_bytes(s_tdata, int'(s_offset[5:0]), s_dir),
                              keep: rot_keep(s_tkeep, int'(s_offset[5:0]), s_dir),
                              last: s_tlast, offset: s_offset, dir: 1'b0});
                sent++;
            end
            @(posedge aclk); #1;
            cyc++;
            if (in_acc || !s_tvalid) begin
                rand_beat();
                s_tvalid = (sent < 1000) ? 1'($urandom) : 1'b0;
            end
            m_tready = 1'($urandom);
        end
        checks++; if (got != 1000) begin errors++; $display("FAIL rand_count got %0d want 1000", got); end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL rand_left got %0d want 0", q.size()); end
        s_tvalid = 1'b0; m_tready = 1'b1;
        got = 0;
        repeat (10) begin @(negedge aclk); if (m_tvalid) got++; end
        checks++; if (got != 0) begin errors++; $display("FAIL rand_dup got %0d want 0", got); end
    endtask

    task automatic test_reset_mid();
        int n;
        @(posedge aclk); #1;
        m_tready = 1'b0;
        s_tdata = ramp; s_tkeep = '1; s_tlast = 1'b0; s_offset = 7'd1; s_dir = 1'b0; s_tvalid = 1'b1;
        repeat (3) @(posedge aclk);
        #1 s_tvalid = 1'b0;
        repeat (8) @(posedge aclk);
        #1;
        checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b want 1", m_tvalid); end
        aresetn = 1'b0;
        #1;
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", m_tvalid); end
        checks++; if (m_tdata !== '0) begin errors++; $display("FAIL mid_rst_data got %h want 0", m_tdata); end
        @(posedge aclk); @(posedge aclk); #1;
        aresetn = 1'b1; m_tready = 1'b1;
        n = 0;
        repeat (12) begin @(negedge aclk); if (m_tvalid) n++; end
        checks++; if (n != 0) begin errors++; $display("FAIL mid_after_release got %0d want 0", n); end
    endtask

`ifdef AXIS_BYTE_ROTATOR_STATS_EN
    task automatic test_stats();
        aresetn = 1'b0; #1; aresetn = 1'b1;
        @(posedge aclk); #1;
        m_tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_tdata = ramp; s_tkeep = '1; s_offset = 7'(i); s_dir = 1'b0; s_tlast = (i == 4 || i == 7); s_tvalid = 1'b1;
            @(posedge aclk); #1;
        end
        s_tvalid = 1'b0;
        repeat (10) @(posedge aclk);
        #1;
        checks++; if (beat_cnt !== 32'd8) begin errors++; $display("FAIL stats_beats got %0d want 8", beat_cnt); end
        checks++; if (pkt_cnt !== 32'd2) begin errors++; $display("FAIL stats_pkts got %0d want 2", pkt_cnt); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int j = 0; j < B; j++) ramp[8*j +: 8] = 8'(j);
        test_reset();
        test_rotate(7'd1, 1'b0, 64'h1, 64'h2, 63, 62, "left1");
        test_rotate(7'd3, 1'b1, 64'h1, 64'h2000_0000_0000_0000, 3, 2, "right3");
        test_rotate(7'd64, 1'b0, 64'hF0F0, 64'hF0F0, 0, 63, "ident64");
        test_rotate(7'd63, 1'b0, 64'h1, 64'h8000_0000_0000_0000, 1, 0, "left63");
        test_comb();
        test_mask_one();
        test_random();
        test_reset_mid();
        test_rotate(7'd2, 1'b1, 64'h4, 64'h1, 2, 1, "after_rst");
`ifdef AXIS_BYTE_ROTATOR_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
